// File: rtl/maze_pkg.sv
// +--------------------------------------------------------------------------+
// | maze_pkg : geometry and default image for the 16x16 maze bit-map          |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package maze_pkg;

  localparam int MAZE_W  = 16;
  localparam int MAZE_H  = 16;
  localparam int MAZE_AW = 4;

  typedef logic [MAZE_W-1:0] maze_row_t;

  // Bit X of word Y is cell (X,Y); start (0,0) and goal (15,15) are open.
  localparam maze_row_t MAZE_INIT [MAZE_H] = '{
    16'h00FE, 16'hEF02, 16'h2A6A, 16'h8A32,
    16'hBBEE, 16'h0820, 16'hEEBB, 16'h2081,
    16'hBB6D, 16'h0A50, 16'hDDB5, 16'h4104,
    16'h5F77, 16'h1005, 16'hF7F4, 16'h0010
  };

endpackage

`default_nettype wire

// File: rtl/maze_memory.sv
// +--------------------------------------------------------------------------+
// | maze_memory : single-port 16x16 wall/open bit-map with registered read    |
// | Option      : MAZE_MEMORY_BYPASS_EN selects write-first on RD+WR          |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module maze_memory
  import maze_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [MAZE_AW-1:0] X,
  input  logic [MAZE_AW-1:0] Y,
  input  logic               D_in,
  input  logic               RD,
  input  logic               WR,
  output logic               D_out
);

  maze_row_t mem_q [MAZE_H];
  maze_row_t mem_d [MAZE_H];
  logic      d_out_q;
  logic      d_out_d;
  logic      rd_bit;

  always_comb begin
    mem_d   = mem_q;
    d_out_d = d_out_q;
    rd_bit  = mem_q[Y][X];

    if (WR) begin
      mem_d[Y][X] = D_in;
    end

    if (RD) begin
`ifdef MAZE_MEMORY_BYPASS_EN
      d_out_d = WR ? D_in : rd_bit;
`else
      d_out_d = rd_bit;
`endif
    end

    // Reset overrides any access sampled on the same edge.
    if (rst) begin
      mem_d   = MAZE_INIT;
      d_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    d_out_q <= d_out_d;
  end

  assign D_out = d_out_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_memory.sv
// +--------------------------------------------------------------------------+
// | tb_maze_memory : directed plus random checks of maze_memory against a     |
// |                  flat 256-cell reference model                            |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_maze_memory;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] X = '0;
  logic [3:0] Y = '0;
  logic       D_in = 1'b0;
  logic       RD = 1'b0;
  logic       WR = 1'b0;
  logic       D_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit   model_mem [256];
  logic model_dout;

  maze_memory dut (
    .clk   (clk),
    .rst   (rst),
    .X     (X),
    .Y     (Y),
    .D_in  (D_in),
    .RD    (RD),
    .WR    (WR),
    .D_out (D_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = MAZE_INIT[i / 16][i % 16];
    model_dout = 1'b0;
  endtask

  // One clock: drive inputs, advance, update model, compare D_out.
  task automatic cyc(input logic rs, input logic r, input logic w,
                     input int x, input int y, input logic din, input string tag);
    int  idx;
    bit  old;
    rst  = rs;
    RD   = r;
    WR   = w;
    X    = x[3:0];
    Y    = y[3:0];
    D_in = din;
    @(posedge clk);
    idx = y * 16 + x;
    if (rs) begin
      model_reset();
    end else begin
      old = model_mem[idx];
      if (r) begin
`ifdef MAZE_MEMORY_BYPASS_EN
        model_dout = w ? din : old;
`else
        model_dout = old;
`endif
      end
      if (w) model_mem[idx] = din;
    end
    #1;
    check(tag, D_out, model_dout);
  endtask

  initial begin
    model_dout = 1'b0;

    // Reset with accesses requested; they must be ignored.
    cyc(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, "reset");
    check("reset_dout_zero", D_out, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "read_start");
    check("start_open", D_out, 1'b0);

    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        cyc(1'b0, 1'b1, 1'b0, x, y, 1'b0, "default_image");
    check("goal_open", D_out, 1'b0);

    cyc(1'b0, 1'b0, 1'b1, 5, 9, 1'b1, "write_5_9");
    cyc(1'b0, 1'b1, 1'b0, 5, 9, 1'b0, "read_5_9");
    check("read_5_9_is_one", D_out, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4, 9, 1'b0, "neighbour_4_9");
    cyc(1'b0, 1'b1, 1'b0, 6, 9, 1'b0, "neighbour_6_9");
    cyc(1'b0, 1'b1, 1'b0, 5, 8, 1'b0, "neighbour_5_8");
    cyc(1'b0, 1'b1, 1'b0, 5, 10, 1'b0, "neighbour_5_10");

    cyc(1'b0, 1'b1, 1'b0, 5, 9, 1'b0, "hold_setup");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, int'($urandom_range(15)), int'($urandom_range(15)),
          1'b0, "hold_model");
      check("hold_one", D_out, 1'b1);
    end

    cyc(1'b0, 1'b1, 1'b1, 3, 3, 1'b1, "rdwr_3_3");
`ifdef MAZE_MEMORY_BYPASS_EN
    check("rdwr_write_first", D_out, 1'b1);
`else
    check("rdwr_read_first", D_out, 1'b0);
`endif
    cyc(1'b0, 1'b1, 1'b0, 3, 3, 1'b0, "after_rdwr");
    check("after_rdwr_one", D_out, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(31) == 0), 1'($urandom), 1'($urandom),
          int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom), "random");
    end

    cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, "write_0_0");
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "read_0_0_written");
    check("read_0_0_one", D_out, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, "mid_reset");
    check("mid_reset_dout", D_out, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "read_0_0_after_reset");
    check("reset_discards_write", D_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
